// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by uart_tx and its arbiter
//   arb_state_t: arbiter sequencing states
//   PARITY/STOP: uart_tx frame format (8N1)
package uart_pkg;
  typedef enum logic [2:0] {ARB, ISSUE, WAIT_BUSY, WAIT_DONE, GAP, HOLD} arb_state_t;
  localparam string PARITY = "NONE";
  localparam string STOP = "1";
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority select
//   req: request vector; ptr: index with highest priority
//   winner: first requesting index at or after ptr (wrapping); any: some request present
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] winner,
  output logic         any
);
  logic [W-1:0] idx;
  assign any = |req;
  // scan farthest-to-nearest so the nearest requester overwrites the rest
  always_comb begin
    winner = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = W'((int'(ptr) + k) % N);
      if (req[idx]) winner = idx;
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin sharing of one uart_tx
//   req/data/last: per-requester byte stream; ack: one-cycle consume pulse
//   grant_id/active: current packet owner and lock flag
//   uart_data/uart_tx_en/uart_busy: handshake with the uart_tx instance
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int GAP_CYCLES = 0,
  parameter int HOLD_TIMEOUT = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*8-1:0]         data,
  input  logic [NUM_REQ-1:0]           last,
  output logic [NUM_REQ-1:0]           ack,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         active,
  output logic [7:0]                   uart_data,
  output logic                         uart_tx_en,
  input  logic                         uart_busy
);
  import uart_pkg::*;
  localparam int W = $clog2(NUM_REQ);
  arb_state_t state, nxt;
  logic [W-1:0] ptr, ptr_d, gid_d, winner, ptr_inc;
  logic         act_d, last_q, last_d, any, resolve, load, rel;
  logic [7:0]   dat_d;
  logic [31:0]  cnt, cnt_d;
  rr_pick #(.N(NUM_REQ)) u_pick (.req(req), .ptr(ptr), .winner(winner), .any(any));
  assign uart_tx_en = state == ISSUE;
  assign ack = uart_tx_en ? NUM_REQ'(1) << grant_id : '0;
  assign ptr_inc = grant_id == W'(NUM_REQ - 1) ? '0 : grant_id + 1'b1;
  always_comb begin
    nxt = state;
    ptr_d = ptr;
    gid_d = grant_id;
    act_d = active;
    dat_d = uart_data;
    last_d = last_q;
    cnt_d = (state == GAP || state == HOLD) ? cnt + 32'd1 : '0;
    resolve = 1'b0;
    load = 1'b0;
    rel = 1'b0;
    case (state)
      ARB: if (any) begin
        nxt = ISSUE;
        gid_d = winner;
        act_d = 1'b1;
        dat_d = data[{winner, 3'b000} +: 8];
        last_d = last[winner];
      end
      ISSUE: nxt = WAIT_BUSY;
      // busy from uart_tx lags tx_en by a cycle; do not trust busy=0 before it rises
      WAIT_BUSY: if (uart_busy) nxt = WAIT_DONE;
      WAIT_DONE: if (!uart_busy) begin
        if (GAP_CYCLES > 0) nxt = GAP;
        else resolve = 1'b1;
      end
      GAP: if (cnt == 32'(GAP_CYCLES - 1)) resolve = 1'b1;
      HOLD: begin
        if (req[grant_id]) load = 1'b1;
        else if (HOLD_TIMEOUT > 0 && cnt == 32'(HOLD_TIMEOUT - 1)) rel = 1'b1;
      end
      default: nxt = ARB;
    endcase
    if (resolve) begin
      if (last_q) rel = 1'b1;
      else if (req[grant_id]) load = 1'b1;
      else begin
        nxt = HOLD;
        cnt_d = '0;
      end
    end
    if (load) begin
      nxt = ISSUE;
      dat_d = data[{grant_id, 3'b000} +: 8];
      last_d = last[grant_id];
    end
    if (rel) begin
      nxt = ARB;
      ptr_d = ptr_inc;
      act_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB;
      ptr <= '0;
      grant_id <= '0;
      active <= 1'b0;
      uart_data <= '0;
      last_q <= 1'b0;
      cnt <= '0;
    end else begin
      state <= nxt;
      ptr <= ptr_d;
      grant_id <= gid_d;
      active <= act_d;
      uart_data <= dat_d;
      last_q <= last_d;
      cnt <= cnt_d;
    end
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_tx instance between NUM_REQ byte-stream requesters. Grants are round-robin at packet granularity: a granted requester keeps the line until it delivers a byte flagged last. The block sequences uart_tx by driving data_in/tx_en and tracking its busy output, issuing one byte per frame. It sits between on-chip message sources (debug, status, log) and the uart_tx instance.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
GAP_CYCLES, 0, idle clk cycles inserted after each frame before the next tx_en (0..65535)
HOLD_TIMEOUT, 0, clk cycles a mid-packet grant waits for the next byte before releasing the lock; 0 = never release

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
req  in  NUM_REQ  per requester: byte valid on data/last
data  in  NUM_REQ*8  byte for requester i at [8i+7:8i]
last  in  NUM_REQ  byte is final of packet
ack  out  NUM_REQ  one-cycle pulse: byte of requester i consumed
grant_id  out  $clog2(NUM_REQ)  currently granted requester
active  out  1  a packet grant is held
uart_data  out  8  to uart_tx data_in
uart_tx_en  out  1  to uart_tx tx_en
uart_busy  in  1  from uart_tx busy

Behaviour:
- Reset: state ARB, rr pointer 0, grant_id 0, active 0, ack 0, uart_tx_en 0, uart_data 0x00, counters 0. Reset shares rst_n with uart_tx; reset mid-frame drops the packet silently.
- Requester contract: req held with data/last stable until ack; ack only when req=1.
- States: ARB, ISSUE, WAIT_BUSY, WAIT_DONE, GAP, HOLD.
- ARB: if |req, winner = first i with req[i]=1 searching ptr, ptr+1, ... wrapping mod NUM_REQ. At that edge: grant_id<=winner, active<=1, uart_data<=data[winner], last_q<=last[winner] -> ISSUE. Else stay.
- ISSUE (exactly one cycle): uart_tx_en=1, ack[grant_id]=1 -> WAIT_BUSY. uart_tx_en and ack are decoded from registered state only.
- WAIT_BUSY: wait uart_busy=1 (expected next cycle) -> WAIT_DONE. Guards against sampling stale busy=0.
- WAIT_DONE: when uart_busy=0: GAP_CYCLES>0 -> GAP (counter cleared); else resolve.
- GAP: count to GAP_CYCLES-1, then resolve.
- Resolve: last_q=1 -> ARB, ptr<=(grant_id+1) mod NUM_REQ, active<=0. Else if req[grant_id]=1 -> ISSUE, loading uart_data/last_q from it. Else -> HOLD.
- HOLD: req[grant_id]=1 -> load, ISSUE. HOLD_TIMEOUT>0 and hold count reaches HOLD_TIMEOUT-1 -> ARB, ptr advances, active<=0. Other requesters are ignored while held.
- Simultaneous: req from non-granted requesters never pre-empts; a byte arriving on the timeout cycle wins (issued, no release).
- Throughput: GAP_CYCLES=0 gives 2 clk overhead per byte (ISSUE + resolve edge) beyond the uart frame.
- uart_data changes only on edges entering ISSUE; stable while uart_busy=1.
- grant_id retains its last value after release.

Decomposition:
- uart_pkg: arb_state_t enum (six states), and PARITY/STOP string constants shared with uart_tx.
- Sub-module rr_pick: combinational round-robin priority select (req vector, ptr -> winner index, any_valid); reused by later arbiters.

Test Plan:
- NUM_REQ=4, CLK_FREQ=50, BAUD_RATE=115200, 8N1 uart_tx: req[2] sends 0x55 last=1 -> ack[2] single pulse, tx_out frame 0,1,0,1,0,1,0,1,0,1 at 434 clk/bit, active falls after stop bit.
- req[0] and req[3] both asserted single-byte packets, ptr=0 -> order 0,3,0,3 alternating; ack never to both in one cycle.
- req[1] 3-byte packet 0xA1,0xA2,0xA3 (last on third) with req[0] asserted throughout -> three bytes from 1 contiguous, then 0 granted; grant_id=1 for whole packet.
- HOLD_TIMEOUT=1000: req[1] sends byte last=0 then drops req; req[2] pending -> grant released 1000 clk after stop bit, req[2] granted next, no ack to 1.
- GAP_CYCLES=100: two back-to-back bytes -> uart_tx_en pulses separated by frame length + 100 + 2 clk.
- Assert rst_n low mid-frame of 0x3C -> next cycle ack=0, uart_tx_en=0, active=0, tx_out=1; after release, pending req granted from ptr 0.
